// File: rtl/spi_slave_mlf.sv
// SPI slave: oversamples SCLK/MOSI/CS_n in the i_clk domain, shifts bytes MSB-first, counts bytes per frame.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) outside an active frame for a shared bus.
module spi_slave_mlf #(
   parameter int          SPI_MODE         = 0,
   parameter int          MAX_BYTES_PER_CS = 2,
   parameter logic [7:0]  DEFAULT_TX_BYTE  = 8'hFF,
   localparam int         CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_TX_Byte,
   input  logic          i_TX_DV,
   output logic          o_TX_Ready,
   output logic          o_TX_Underrun,
   output logic          o_RX_DV,
   output logic [7:0]    o_RX_Byte,
   output logic [CW-1:0] o_RX_count,
   input  logic          i_SPI_clk,
   input  logic          i_SPI_MOSI,
   output logic          o_SPI_MISO,
   input  logic          i_SPI_CS_n
);
   localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
   localparam bit CPHA = (SPI_MODE % 2) == 1;

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t r_state, w_state_next;

   logic [2:0]    r_sclk_sync, r_csn_sync;
   logic [1:0]    r_mosi_sync;
   logic [7:0]    r_rx_shreg, r_tx_shreg, r_rx_byte, r_hold_byte;
   logic [2:0]    r_bit_cnt;
   logic [CW-1:0] r_rx_count;
   logic          r_rx_dv, r_tx_underrun, r_hold_full;
   logic          w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
   logic          w_cs_fall, w_cs_rise, w_byte_start;

   // CS_n sync resets low so a CS_n held low across reset never looks like a fresh fall
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sclk_sync <= {3{CPOL}};
         r_csn_sync  <= '0;
         r_mosi_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], i_SPI_clk};
         r_csn_sync  <= {r_csn_sync[1:0], i_SPI_CS_n};
         r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
      end
   end

   assign w_rise       = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_fall       = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign w_lead       = CPOL ? w_fall : w_rise;
   assign w_trail      = CPOL ? w_rise : w_fall;
   assign w_sample     = CPHA ? w_trail : w_lead;
   assign w_shift      = CPHA ? w_lead : w_trail;
   assign w_cs_fall    = r_csn_sync[2] & ~r_csn_sync[1];
   assign w_cs_rise    = ~r_csn_sync[2] & r_csn_sync[1];
   assign w_byte_start = ((r_state == IDLE) && w_cs_fall) ||
                         ((r_state == ACTIVE) && w_sample && (r_bit_cnt == 3'd7));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
         ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_shreg    <= '0;
         r_tx_shreg    <= '0;
         r_rx_byte     <= '0;
         r_hold_byte   <= '0;
         r_bit_cnt     <= '0;
         r_rx_count    <= '0;
         r_rx_dv       <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_hold_full   <= 1'b0;
      end else begin
         r_rx_dv       <= 1'b0;
         r_tx_underrun <= 1'b0;
         if (r_state == IDLE) begin
            r_bit_cnt  <= '0;
            r_rx_count <= '0;
         end else if (w_sample) begin
            r_rx_shreg <= {r_rx_shreg[6:0], r_mosi_sync[1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_rx_byte <= {r_rx_shreg[6:0], r_mosi_sync[1]};
               r_rx_dv   <= 1'b1;
               if (r_rx_count != CW'(MAX_BYTES_PER_CS)) r_rx_count <= r_rx_count + CW'(1);
            end
         // The MSB is already on the line at byte start, so the first shift edge of a byte is skipped
         end else if (w_shift && (r_bit_cnt != 3'd0)) begin
            r_tx_shreg <= {r_tx_shreg[6:0], 1'b0};
         end
         if (w_byte_start) begin
            if (r_hold_full) begin
               r_tx_shreg  <= r_hold_byte;
               r_hold_full <= 1'b0;
            end else begin
               r_tx_shreg    <= DEFAULT_TX_BYTE;
               r_tx_underrun <= 1'b1;
            end
         end
         if (i_TX_DV && !r_hold_full) begin
            r_hold_byte <= i_TX_Byte;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign o_TX_Ready    = ~r_hold_full;
   assign o_TX_Underrun = r_tx_underrun;
   assign o_RX_DV       = r_rx_dv;
   assign o_RX_Byte     = r_rx_byte;
   assign o_RX_count    = r_rx_count;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   assign o_SPI_MISO = (i_rst || r_csn_sync[1] || (r_state != ACTIVE)) ? 1'bz : r_tx_shreg[7];
`else
   assign o_SPI_MISO = r_tx_shreg[7];
`endif
endmodule

// File: tb/tb_spi_slave_mlf.sv
// Directed bench for spi_slave_mlf: one instance per SPI mode, a bit-banged master and pulse counters.
module tb_spi_slave_mlf;
   localparam int HALF = 6;

   logic       clk, rst, sclk, mosi;
   logic [7:0] tx_byte;
   logic [3:0] tx_dv, cs_n, tx_ready, underrun, rx_dv, miso;
   logic [7:0] rx_byte  [4];
   logic [1:0] rx_count [4];
   int         dv_cnt   [4] = '{0, 0, 0, 0};
   int         unf_cnt  [4] = '{0, 0, 0, 0};
   int         checks = 0;
   int         errors = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_mlf #(.SPI_MODE(g), .MAX_BYTES_PER_CS(2), .DEFAULT_TX_BYTE(8'hFF)) u_dut (
         .i_clk(clk), .i_rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[g]),
         .o_TX_Ready(tx_ready[g]), .o_TX_Underrun(underrun[g]), .o_RX_DV(rx_dv[g]),
         .o_RX_Byte(rx_byte[g]), .o_RX_count(rx_count[g]), .i_SPI_clk(sclk),
         .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[g]), .i_SPI_CS_n(cs_n[g]));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int g = 0; g < 4; g++) begin
         dv_cnt[g]  <= dv_cnt[g] + int'(rx_dv[g]);
         unf_cnt[g] <= unf_cnt[g] + int'(underrun[g]);
      end
   end

   initial begin
      #200us;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_tx(input int g, input logic [7:0] b);
      tx_byte   = b;
      tx_dv[g]  = 1'b1;
      tick(1);
      tx_dv[g]  = 1'b0;
      tick(1);
   endtask

   task automatic cs_low(input int g);
      cs_n[g] = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_high(input int g);
      cs_n[g] = 1'b1;
      tick(HALF);
   endtask

   task automatic xfer_byte(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
      logic cpol, cpha;
      cpol = ((m / 2) % 2) == 1;
      cpha = (m % 2) == 1;
      mi   = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         if (!cpha) begin
            mosi = mo[i];
            tick(HALF);
            mi   = {mi[6:0], miso[m]};
            sclk = ~cpol;
            tick(HALF);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[i];
            tick(HALF);
            mi   = {mi[6:0], miso[m]};
            sclk = cpol;
            tick(HALF);
         end
      end
      tick(HALF);
   endtask

   initial begin
      logic [7:0] rd;
      int d, u;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = '1; tx_dv = '0; tx_byte = 8'h00;
      tick(3);
      check("rst_rx_dv",    32'(rx_dv[0]),    0);
      check("rst_rx_byte",  32'(rx_byte[0]),  0);
      check("rst_rx_count", 32'(rx_count[0]), 0);
      check("rst_tx_ready", 32'(tx_ready[0]), 1);
      check("rst_underrun", 32'(underrun[0]), 0);
      check("rst_miso",     32'(miso[0]),     0);
      rst = 1'b0;
      tick(5);

      // mode 0, preloaded 3C, master sends A5
      load_tx(0, 8'h3C);
      check("t1_ready_lo", 32'(tx_ready[0]), 0);
      d = dv_cnt[0];
      cs_low(0);
      check("t1_ready_hi", 32'(tx_ready[0]), 1);
      xfer_byte(0, 8'hA5, 8, rd);
      check("t1_master_rd", 32'(rd), 32'h3C);
      check("t1_dv_pulses", 32'(dv_cnt[0] - d), 1);
      check("t1_rx_byte",   32'(rx_byte[0]), 32'hA5);
      check("t1_rx_count",  32'(rx_count[0]), 1);
      cs_high(0);
      check("t1_count_idle", 32'(rx_count[0]), 0);

      // mode 3, two bytes in one frame, reload after first start
      sclk = 1'b1;
      tick(HALF);
      load_tx(3, 8'hC3);
      d = dv_cnt[3];
      cs_low(3);
      load_tx(3, 8'h56);
      xfer_byte(3, 8'h12, 8, rd);
      check("t2_rd0",    32'(rd), 32'hC3);
      check("t2_rx0",    32'(rx_byte[3]), 32'h12);
      check("t2_count0", 32'(rx_count[3]), 1);
      xfer_byte(3, 8'h34, 8, rd);
      check("t2_rd1",    32'(rd), 32'h56);
      check("t2_rx1",    32'(rx_byte[3]), 32'h34);
      check("t2_count1", 32'(rx_count[3]), 2);
      check("t2_dv_pulses", 32'(dv_cnt[3] - d), 2);
      cs_high(3);

      // mode 0, nothing loaded: default byte and underrun at frame start
      sclk = 1'b0;
      tick(HALF);
      u = unf_cnt[0];
      cs_low(0);
      check("t3_underrun", 32'(unf_cnt[0] - u), 1);
      check("t3_ready",    32'(tx_ready[0]), 1);
      xfer_byte(0, 8'h00, 8, rd);
      check("t3_master_rd", 32'(rd), 32'hFF);
      check("t3_rx_byte",   32'(rx_byte[0]), 32'h00);
      cs_high(0);
      check("t3_ready_end", 32'(tx_ready[0]), 1);

      // aborted partial byte, then a clean frame
      d = dv_cnt[0];
      cs_low(0);
      xfer_byte(0, 8'hF0, 5, rd);
      cs_high(0);
      check("t4_abort_dv",    32'(dv_cnt[0] - d), 0);
      check("t4_abort_count", 32'(rx_count[0]), 0);
      check("t4_abort_byte",  32'(rx_byte[0]), 32'h00);
      cs_low(0);
      xfer_byte(0, 8'h5A, 8, rd);
      check("t4_rx_byte", 32'(rx_byte[0]), 32'h5A);
      check("t4_count",   32'(rx_count[0]), 1);
      check("t4_dv",      32'(dv_cnt[0] - d), 1);
      cs_high(0);

      // mode 1: 81 both ways, then saturation over 3 bytes
      load_tx(1, 8'h81);
      d = dv_cnt[1];
      cs_low(1);
      xfer_byte(1, 8'h81, 8, rd);
      check("t5_m1_rd",    32'(rd), 32'h81);
      check("t5_m1_rx",    32'(rx_byte[1]), 32'h81);
      check("t5_m1_count", 32'(rx_count[1]), 1);
      xfer_byte(1, 8'h00, 8, rd);
      check("t5_count2",   32'(rx_count[1]), 2);
      xfer_byte(1, 8'hFF, 8, rd);
      check("t5_count_sat", 32'(rx_count[1]), 2);
      check("t5_dv_pulses", 32'(dv_cnt[1] - d), 3);
      check("t5_rx_last",   32'(rx_byte[1]), 32'hFF);
      cs_high(1);

      // mode 2: 81 both ways
      sclk = 1'b1;
      tick(HALF);
      load_tx(2, 8'h81);
      cs_low(2);
      xfer_byte(2, 8'h81, 8, rd);
      check("t5_m2_rd", 32'(rd), 32'h81);
      check("t5_m2_rx", 32'(rx_byte[2]), 32'h81);
      cs_high(2);

      // reset mid-byte with a held byte pending
      sclk = 1'b0;
      tick(HALF);
      load_tx(0, 8'h77);
      cs_low(0);
      load_tx(0, 8'hEE);
      xfer_byte(0, 8'hC9, 4, rd);
      rst = 1'b1;
      #1;
      check("t6_rx_dv",    32'(rx_dv[0]),    0);
      check("t6_rx_byte",  32'(rx_byte[0]),  0);
      check("t6_rx_count", 32'(rx_count[0]), 0);
      check("t6_tx_ready", 32'(tx_ready[0]), 1);
      check("t6_underrun", 32'(underrun[0]), 0);
      check("t6_miso",     32'(miso[0]),     0);
      tick(2);
      rst = 1'b0;
      tick(HALF);
      d = dv_cnt[0];
      xfer_byte(0, 8'hC9, 8, rd);
      check("t6_no_resume_dv",    32'(dv_cnt[0] - d), 0);
      check("t6_no_resume_count", 32'(rx_count[0]), 0);
      cs_high(0);
      cs_low(0);
      xfer_byte(0, 8'hC9, 8, rd);
      check("t6_new_rx",    32'(rx_byte[0]), 32'hC9);
      check("t6_new_count", 32'(rx_count[0]), 1);
      check("t6_new_dv",    32'(dv_cnt[0] - d), 1);
      check("t6_new_rd",    32'(rd), 32'hFF);
      cs_high(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
